dpot_wiper_ctrl: RTL and testbench

- Digital-side wiper controller for the digital potentiometer analog macro.
- Decodes a two-wire CS/U-D step protocol from the pins into a saturating wiper position register.
- Drives the resistor-ladder switch array as a thermometer code and serialises the current wiper position back out on request.
- Sits between the tile's dedicated inputs/outputs and the analog ladder inside the top-level wrapper.

---
 rtl/dpot_wiper_ctrl.sv | 135 +++++++++++++
 tb/tb_dpot_wiper_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dpot_wiper_ctrl.sv
// Wiper controller for the digital potentiometer: CS/U-D step decoder with a saturating
// position register, a thermometer-coded ladder drive and an MSB-first serial readback.
module dpot_wiper_ctrl #(
  parameter int WIDTH     = 6,
  parameter int RESET_POS = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cs_n,
  input  logic                    ud,
  input  logic                    rd,
  output logic [WIDTH-1:0]        wiper,
  output logic [(1<<WIDTH)-2:0]   therm,
  output logic                    at_min,
  output logic                    at_max,
  output logic                    sdo,
  output logic                    sdo_valid,
  output logic                    busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAX_POS = '1;

  typedef enum logic [1:0] {IDLE, INC, DEC} step_t;
  typedef enum logic {RIDLE, SHIFT} rb_t;

  // Handshake: rd is a one-cycle request accepted only in RIDLE; sdo is
  // meaningful exactly while sdo_valid is high, and there is no back-pressure.

  logic cs_s1, cs_s2, cs_prev;
  logic ud_s1, ud_s2, ud_prev;
  logic cs_fall, cs_rise, ud_rise;

  step_t step_state, step_next;
  logic  step_up, step_dn;

  rb_t               rb_state, rb_next;
  logic [WIDTH-1:0]  shift_reg;
  logic [CW-1:0]     bit_cnt;

  // Synchronizers idle high so that reset release with pins high produces no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_prev <= 1'b1;
      ud_s1   <= 1'b1;
      ud_s2   <= 1'b1;
      ud_prev <= 1'b1;
    end else begin
      cs_s1   <= cs_n;
      cs_s2   <= cs_s1;
      cs_prev <= cs_s2;
      ud_s1   <= ud;
      ud_s2   <= ud_s1;
      ud_prev <= ud_s2;
    end
  end

  assign cs_fall = cs_prev & ~cs_s2;
  assign cs_rise = ~cs_prev & cs_s2;
  assign ud_rise = ~ud_prev & ud_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_state <= IDLE;
    else        step_state <= step_next;
  end

  always_comb begin
    step_next = step_state;
    step_up   = 1'b0;
    step_dn   = 1'b0;
    case (step_state)
      IDLE: if (cs_fall) step_next = ud_s2 ? INC : DEC;
      INC: begin
        if (cs_rise)      step_next = IDLE;
        else if (ud_rise) step_up   = 1'b1;
      end
      DEC: begin
        if (cs_rise)      step_next = IDLE;
        else if (ud_rise) step_dn   = 1'b1;
      end
      default: step_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wiper <= WIDTH'(RESET_POS);
    end else if (step_up && wiper != MAX_POS) begin
      wiper <= wiper + WIDTH'(1);
    end else if (step_dn && wiper != '0) begin
      wiper <= wiper - WIDTH'(1);
    end
  end

  for (genvar i = 0; i < (1 << WIDTH) - 1; i++) begin : g_therm
    assign therm[i] = (wiper > WIDTH'(i));
  end

  assign at_min = (wiper == '0);
  assign at_max = (wiper == MAX_POS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rb_state <= RIDLE;
    else        rb_state <= rb_next;
  end

  always_comb begin
    rb_next = rb_state;
    case (rb_state)
      RIDLE:   if (rd) rb_next = SHIFT;
      SHIFT:   if (bit_cnt == CW'(1)) rb_next = RIDLE;
      default: rb_next = RIDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (rb_state == RIDLE && rd) begin
      shift_reg <= wiper;
      bit_cnt   <= CW'(WIDTH);
    end else if (rb_state == SHIFT) begin
      shift_reg <= shift_reg << 1;
      bit_cnt   <= bit_cnt - CW'(1);
    end
  end

  assign sdo_valid = (rb_state == SHIFT);
  assign sdo       = sdo_valid & shift_reg[WIDTH-1];
  assign busy      = (step_state != IDLE) || (rb_state != RIDLE);

endmodule

// File: tb/tb_dpot_wiper_ctrl.sv
// Self-checking bench for dpot_wiper_ctrl: directed sessions with randomized hold times
// and targets, checked against an integer model of the wiper and an expected readback queue.
module tb_dpot_wiper_ctrl;
  localparam int WIDTH = 6;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic clk, rst_n, cs_n, ud, rd;
  logic [WIDTH-1:0]      wiper;
  logic [(1<<WIDTH)-2:0] therm;
  logic at_min, at_max, sdo, sdo_valid, busy;

  int n_checks = 0;
  int n_fails  = 0;
  int exp_w    = 32;
  logic [0:0] exp_q[$];

  dpot_wiper_ctrl #(.WIDTH(WIDTH), .RESET_POS(32)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .ud(ud), .rd(rd),
    .wiper(wiper), .therm(therm), .at_min(at_min), .at_max(at_max),
    .sdo(sdo), .sdo_valid(sdo_valid), .busy(busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(string tag);
    logic [62:0] t_exp;
    for (int i = 0; i < MAXV; i++) t_exp[i] = (exp_w > i);
    chk({tag, "_wiper"},  64'(wiper),  64'(exp_w));
    chk({tag, "_therm"},  64'(therm),  64'(t_exp));
    chk({tag, "_at_min"}, 64'(at_min), 64'(exp_w == 0));
    chk({tag, "_at_max"}, 64'(at_max), 64'(exp_w == MAXV));
  endtask

  // driver tasks
  task automatic open_session(bit up);
    ud = up;
    tick(4);
    cs_n = 1'b0;
    tick(5);
    chk("session_busy", 64'(busy), 64'(1));
  endtask

  task automatic close_session();
    cs_n = 1'b1;
    tick(5);
    chk("idle_busy", 64'(busy), 64'(0));
    check_outputs("close");
  endtask

  task automatic ud_pulse(bit up);
    int h;
    int cnt;
    int nxt;
    h = $urandom_range(3, 5);
    ud = 1'b0;
    tick(h);
    nxt = up ? ((exp_w < MAXV) ? exp_w + 1 : MAXV) : ((exp_w > 0) ? exp_w - 1 : 0);
    ud = 1'b1;
    if (nxt != exp_w) begin
      cnt = 0;
      do begin
        tick();
        cnt++;
      end while (32'(wiper) != nxt && cnt < 8);
      chk("step_latency", 64'(cnt == 3 || cnt == 4), 64'(1));
      tick(h);
    end else begin
      tick(h + 4);
    end
    exp_w = nxt;
    check_outputs("step");
  endtask

  task automatic goto_pos(int target);
    int d;
    if (target == exp_w) return;
    d = (target > exp_w) ? target - exp_w : exp_w - target;
    if (target > exp_w) begin
      open_session(1'b1);
      repeat (d) ud_pulse(1'b1);
    end else begin
      open_session(1'b0);
      repeat (d) ud_pulse(1'b0);
    end
    close_session();
  endtask

  // Readback of the model value; optional extra rd pulses mid-shift and on the
  // last bit, and an optional ud rising edge so a step lands inside the shift.
  task automatic readback(bit extra_rd, bit with_step);
    int val;
    val = exp_w;
    for (int k = WIDTH - 1; k >= 0; k--) exp_q.push_back(1'((val >> k) & 1));
    rd = 1'b1;
    if (with_step) ud = 1'b1;
    tick();
    rd = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      chk("rb_valid", 64'(sdo_valid), 64'(1));
      chk("rb_bit", 64'(sdo), 64'(exp_q.pop_front()));
      rd = extra_rd && (k == 1 || k == WIDTH - 1);
      tick();
    end
    rd = 1'b0;
    chk("rb_valid_end", 64'(sdo_valid), 64'(0));
    chk("rb_sdo_end", 64'(sdo), 64'(0));
    tick(3);
    chk("rb_no_requeue", 64'(sdo_valid), 64'(0));
    if (with_step) begin
      exp_w = (exp_w < MAXV) ? exp_w + 1 : MAXV;
      check_outputs("rb_step");
    end
  endtask

  task automatic release_reset();
    cs_n = 1'b1;
    ud   = 1'b1;
    rd   = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(3);
    check_outputs("post_reset");
    chk("post_reset_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    cs_n  = 1'($urandom_range(0, 1));
    ud    = 1'($urandom_range(0, 1));
    rd    = 1'($urandom_range(0, 1));
    tick(3);
    exp_w = 32;
    check_outputs("reset");
    chk("reset_sdo_valid", 64'(sdo_valid), 64'(0));
    chk("reset_sdo", 64'(sdo), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    release_reset();

    // increment 32 -> 37
    open_session(1'b1);
    repeat (5) ud_pulse(1'b1);
    close_session();
    chk("inc_37", 64'(wiper), 64'(37));

    // readback of 37 with ignored extra requests
    readback(1'b1, 1'b0);

    // readback with a concurrent INC step
    open_session(1'b1);
    ud = 1'b0;
    tick(4);
    readback(1'b0, 1'b1);
    close_session();

    // random targets followed by readback
    for (int r = 0; r < 3; r++) begin
      goto_pos($urandom_range(0, MAXV));
      readback(1'($urandom_range(0, 1)), 1'b0);
    end

    // decrement to the floor
    goto_pos(2);
    open_session(1'b0);
    repeat (4) ud_pulse(1'b0);
    close_session();
    chk("floor_at_min", 64'(at_min), 64'(1));

    // saturate high
    goto_pos(60);
    open_session(1'b1);
    repeat (10) ud_pulse(1'b1);
    close_session();
    chk("ceiling_at_max", 64'(at_max), 64'(1));

    // abort mid-shift
    rd = 1'b1;
    tick();
    rd = 1'b0;
    tick(2);
    chk("abort_shift_pre", 64'(sdo_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    exp_w = 32;
    chk("abort_shift_valid", 64'(sdo_valid), 64'(0));
    chk("abort_shift_busy", 64'(busy), 64'(0));
    chk("abort_shift_wiper", 64'(wiper), 64'(32));
    release_reset();

    // abort mid-INC with a step still in the synchronizer
    open_session(1'b1);
    ud = 1'b0;
    tick(4);
    ud = 1'b1;
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_inc_wiper", 64'(wiper), 64'(32));
    chk("abort_inc_busy", 64'(busy), 64'(0));
    release_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
